// File: rtl/dehaze_pkg.sv
// Shared widths and helpers for the dehaze pipeline, including the 1/t format
// exchanged between transmission estimation and radiance recovery.
package dehaze_pkg;
  localparam int PIX_W    = 8;
  localparam int INV_W    = 11;
  localparam int INV_FRAC = 8;
  localparam int DIFF_W   = 9;
  localparam int PROD_W   = 20;
  localparam int SCL_W    = 12;
  localparam int SUM_W    = 13;

  // 1/t as unsigned UQ3.8: value / 256.
  typedef logic [INV_W-1:0] one_by_t_t;

  function automatic logic [PIX_W-1:0] sat_u8(input logic signed [SUM_W-1:0] v);
    if (v < 0)
      sat_u8 = '0;
    else if (v > 13'sd255)
      sat_u8 = '1;
    else
      sat_u8 = v[PIX_W-1:0];
  endfunction
endpackage

// File: rtl/radiance_channel.sv
// One colour channel of J = A + (I - A) * (1/t): clamp/diff, scale, add/saturate.
module radiance_channel
  import dehaze_pkg::*;
#(
  parameter int MAX_INV = 1280
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en1,
  input  logic             i_en2,
  input  logic             i_en3,
  input  logic [PIX_W-1:0] i_pix,
  input  logic [PIX_W-1:0] i_a,
  input  one_by_t_t        i_inv,
  output logic [PIX_W-1:0] o_pix
);
  localparam one_by_t_t INV_CEIL = INV_W'(MAX_INV);

  one_by_t_t                 w_inv;
  logic signed [DIFF_W-1:0]  w_diff;
  logic signed [PROD_W-1:0]  w_diff_x;
  logic signed [PROD_W-1:0]  w_inv_x;
  logic signed [PROD_W-1:0]  w_prod;
  logic signed [SCL_W-1:0]   w_scaled;
  logic signed [SUM_W-1:0]   w_sum;

  logic signed [DIFF_W-1:0]  r1_diff;
  one_by_t_t                 r1_inv;
  logic [PIX_W-1:0]          r1_a;
  logic signed [SCL_W-1:0]   r2_scaled;
  logic [PIX_W-1:0]          r2_a;

  assign w_inv    = (i_inv > INV_CEIL) ? INV_CEIL : i_inv;
  assign w_diff   = $signed({1'b0, i_pix}) - $signed({1'b0, i_a});
  // |diff| <= 255 and inv <= 1280 keep the product inside 20 signed bits.
  assign w_diff_x = PROD_W'(r1_diff);
  assign w_inv_x  = $signed(PROD_W'({1'b0, r1_inv}));
  assign w_prod   = w_diff_x * w_inv_x;
  assign w_scaled = SCL_W'(w_prod >>> INV_FRAC);
  assign w_sum    = {r2_scaled[SCL_W-1], r2_scaled} + {5'b0, r2_a};

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r1_diff   <= '0;
      r1_inv    <= '0;
      r1_a      <= '0;
      r2_scaled <= '0;
      r2_a      <= '0;
      o_pix     <= '0;
    end else begin
      if (i_en1) begin
        r1_diff <= w_diff;
        r1_inv  <= w_inv;
        r1_a    <= i_a;
      end
      if (i_en2) begin
        r2_scaled <= w_scaled;
        r2_a      <= r1_a;
      end
      if (i_en3)
        o_pix <= sat_u8(w_sum);
    end
  end
endmodule

// File: rtl/radiance_recover.sv
// Dehazed RGB recovery: three-stage elastic pipeline with frame markers.
module radiance_recover
  import dehaze_pkg::*;
#(
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480,
  parameter int MAX_INV    = 1280
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_valid,
  output logic             o_ready_in,
  input  logic [PIX_W-1:0] i_r,
  input  logic [PIX_W-1:0] i_g,
  input  logic [PIX_W-1:0] i_b,
  input  logic [PIX_W-1:0] i_ar,
  input  logic [PIX_W-1:0] i_ag,
  input  logic [PIX_W-1:0] i_ab,
  input  one_by_t_t        i_one_by_t,
  output logic             o_valid,
  input  logic             i_ready,
  output logic [PIX_W-1:0] o_r,
  output logic [PIX_W-1:0] o_g,
  output logic [PIX_W-1:0] o_b,
  output logic             o_sof,
  output logic             o_eol,
  output logic             o_eof
);
  localparam int CW = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
  localparam int RW = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_WIDTH - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_HEIGHT - 1);

  logic          r_v1, r_v2, r_v3;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic          w_ld1, w_ld2, w_ld3;
  logic          w_out_xfer;

  // Handshake: a beat moves on a side when valid & ready are both high at the
  // clock edge. A stage loads when it is empty or its successor loads, so
  // bubbles collapse; o_ready_in depends on i_ready and stage valids only.
  assign w_ld3      = !r_v3 || i_ready;
  assign w_ld2      = !r_v2 || w_ld3;
  assign w_ld1      = !r_v1 || w_ld2;
  assign o_ready_in = w_ld1;
  assign o_valid    = r_v3;
  assign w_out_xfer = r_v3 && i_ready;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_v1 <= 1'b0;
      r_v2 <= 1'b0;
      r_v3 <= 1'b0;
    end else begin
      if (w_ld1) r_v1 <= i_valid;
      if (w_ld2) r_v2 <= r_v1;
      if (w_ld3) r_v3 <= r_v2;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_col <= '0;
      r_row <= '0;
    end else if (w_out_xfer) begin
      if (r_col == COL_LAST) begin
        r_col <= '0;
        r_row <= (r_row == ROW_LAST) ? '0 : r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Markers are gated by o_valid so they read 0 while the output is idle.
  assign o_sof = r_v3 && (r_col == '0) && (r_row == '0);
  assign o_eol = r_v3 && (r_col == COL_LAST);
  assign o_eof = o_eol && (r_row == ROW_LAST);

  radiance_channel #(.MAX_INV(MAX_INV)) u_ch_r (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en1(w_ld1 && i_valid), .i_en2(w_ld2 && r_v1), .i_en3(w_ld3 && r_v2),
    .i_pix(i_r), .i_a(i_ar), .i_inv(i_one_by_t), .o_pix(o_r)
  );

  radiance_channel #(.MAX_INV(MAX_INV)) u_ch_g (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en1(w_ld1 && i_valid), .i_en2(w_ld2 && r_v1), .i_en3(w_ld3 && r_v2),
    .i_pix(i_g), .i_a(i_ag), .i_inv(i_one_by_t), .o_pix(o_g)
  );

  radiance_channel #(.MAX_INV(MAX_INV)) u_ch_b (
    .i_clk(i_clk), .i_rst_n(i_rst_n),
    .i_en1(w_ld1 && i_valid), .i_en2(w_ld2 && r_v1), .i_en3(w_ld3 && r_v2),
    .i_pix(i_b), .i_a(i_ab), .i_inv(i_one_by_t), .o_pix(o_b)
  );
endmodule
